// File: rtl/spi_burst_ctrl.sv
// spi_burst_ctrl: TX/RX FIFO byte-burst sequencer feeding an spi_master core.
// Define SPI_BURST_ABORT_EN to make the abort input terminate a running burst.
module spi_burst_ctrl #(
    parameter int  DEPTH      = 16,
    parameter int  GAP_CYCLES = 0,
    localparam int LW         = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tx_wr_valid,
    input  logic [7:0]    tx_wr_data,
    output logic          tx_wr_ready,
    input  logic          rx_rd_ready,
    output logic          rx_rd_valid,
    output logic [7:0]    rx_rd_data,
    input  logic          burst_start,
    input  logic [7:0]    burst_len,
    input  logic          rx_discard,
    input  logic          clear,
    input  logic          abort,
    output logic          core_start,
    output logic [7:0]    core_tx_data,
    input  logic          core_done,
    input  logic [7:0]    core_rx_data,
    output logic          cs_hold,
    output logic          busy,
    output logic [LW-1:0] tx_level,
    output logic [LW-1:0] rx_level,
    output logic          rx_overflow,
    output logic          irq_done
);
    localparam int AW = LW - 1;
    localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_DONE, GAP, FINISH} state_t;

    state_t        state_q, state_d;
    logic [7:0]    rem_q, rem_d, txd_q, txd_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          disc_q, disc_d, pend_q, pend_d, cs_q, cs_d;
    logic          irq_q, irq_d, start_q, start_d, ovf_q;
    logic [LW-1:0] tx_wptr_q, tx_rptr_q, rx_wptr_q, rx_rptr_q;
    logic [7:0]    tx_mem [DEPTH];
    logic [7:0]    rx_mem [DEPTH];
    logic          tx_push, tx_pop, rx_push, rx_pop, rx_wr, rx_full, clr, abort_en;

`ifdef SPI_BURST_ABORT_EN
    assign abort_en = abort;
`else
    logic unused_abort;
    assign unused_abort = abort;
    assign abort_en     = 1'b0;
`endif

    // Levels never exceed DEPTH, so the MSB alone marks a full FIFO.
    assign tx_level     = tx_wptr_q - tx_rptr_q;
    assign rx_level     = rx_wptr_q - rx_rptr_q;
    assign tx_wr_ready  = !tx_level[LW-1];
    assign rx_full      = rx_level[LW-1];
    assign rx_rd_valid  = rx_level != '0;
    assign rx_rd_data   = rx_mem[rx_rptr_q[AW-1:0]];
    assign clr          = clear && state_q == IDLE;
    assign tx_push      = tx_wr_valid && tx_wr_ready;
    assign rx_pop       = rx_rd_ready && rx_rd_valid;
    assign rx_wr        = rx_push && (!rx_full || rx_pop);
    assign busy         = state_q != IDLE;
    assign cs_hold      = cs_q;
    assign irq_done     = irq_q;
    assign core_start   = start_q;
    assign core_tx_data = txd_q;
    assign rx_overflow  = ovf_q;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        gap_d   = gap_q;
        disc_d  = disc_q;
        pend_d  = pend_q;
        cs_d    = cs_q;
        txd_d   = txd_q;
        irq_d   = 1'b0;
        start_d = 1'b0;
        tx_pop  = 1'b0;
        rx_push = 1'b0;
        case (state_q)
            IDLE: if (burst_start && burst_len != 8'd0) begin
                state_d = LAUNCH;
                rem_d   = burst_len;
                disc_d  = rx_discard;
                pend_d  = 1'b0;
                cs_d    = 1'b1;
            end
            LAUNCH: if (abort_en) state_d = FINISH;
            else if (tx_level != '0) begin
                tx_pop  = 1'b1;
                txd_d   = tx_mem[tx_rptr_q[AW-1:0]];
                start_d = 1'b1;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                // An abort during a transfer is remembered until the byte completes.
                pend_d = pend_q | abort_en;
                if (core_done) begin
                    rx_push = !disc_q;
                    rem_d   = rem_q - 8'd1;
                    gap_d   = GW'(GAP_CYCLES - 1);
                    state_d = (rem_q == 8'd1 || pend_q || abort_en) ? FINISH :
                              (GAP_CYCLES == 0 ? LAUNCH : GAP);
                end
            end
            GAP: if (abort_en) state_d = FINISH;
            else if (gap_q == '0) state_d = LAUNCH;
            else gap_d = gap_q - GW'(1);
            FINISH: begin
                cs_d    = 1'b0;
                irq_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            gap_q     <= '0;
            txd_q     <= '0;
            disc_q    <= 1'b0;
            pend_q    <= 1'b0;
            cs_q      <= 1'b0;
            irq_q     <= 1'b0;
            start_q   <= 1'b0;
            ovf_q     <= 1'b0;
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            gap_q   <= gap_d;
            txd_q   <= txd_d;
            disc_q  <= disc_d;
            pend_q  <= pend_d;
            cs_q    <= cs_d;
            irq_q   <= irq_d;
            start_q <= start_d;
            if (clr) begin
                tx_wptr_q <= '0;
                tx_rptr_q <= '0;
                rx_wptr_q <= '0;
                rx_rptr_q <= '0;
                ovf_q     <= 1'b0;
            end else begin
                if (tx_push) tx_wptr_q <= tx_wptr_q + LW'(1);
                if (tx_pop) tx_rptr_q <= tx_rptr_q + LW'(1);
                if (rx_wr) rx_wptr_q <= rx_wptr_q + LW'(1);
                if (rx_pop) rx_rptr_q <= rx_rptr_q + LW'(1);
                if (rx_push && rx_full && !rx_pop) ovf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr_q[AW-1:0]] <= tx_wr_data;
        if (rx_wr) rx_mem[rx_wptr_q[AW-1:0]] <= core_rx_data;
    end
endmodule
